// File: rtl/bist_pkg.sv
// Shared types and defaults for the ALU BIST response path.
package bist_pkg;

  localparam int unsigned BIST_RESP_W = 9;
  localparam logic [8:0]  BIST_POLY9  = 9'h011;
  localparam logic [8:0]  BIST_SEED9  = 9'h000;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StCompare = 2'd2,
    StDone    = 2'd3
  } ora_state_t;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift-left LFSR with POLY feedback, XOR-ing in
// one W-bit response per enabled cycle. load (seed) takes priority over en.
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned W    = BIST_RESP_W,
  parameter logic [W-1:0] POLY = BIST_POLY9,
  parameter logic [W-1:0] SEED = BIST_SEED9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q, sig_d;

  // Next signature: seed on load, compact one response on en, otherwise hold.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = ({sig_q[W-2:0], 1'b0} ^ ({W{sig_q[W-1]}} & POLY)) ^ data;
    end
  end

  // Signature register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_ora.sv
// Output response analyzer: compacts NUM_PATTERNS ALU responses into a MISR and
// checks the final signature against golden_sig.
// Optional per-pattern first-failure capture: define BIST_ORA_FIRST_FAIL_EN.
module bist_ora
  import bist_pkg::*;
#(
  parameter int unsigned  W            = BIST_RESP_W,
  parameter int unsigned  NUM_PATTERNS = 256,
  parameter logic [W-1:0] POLY         = BIST_POLY9,
  parameter logic [W-1:0] SEED         = BIST_SEED9,
  parameter int unsigned  CW           = $clog2(NUM_PATTERNS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          resp_valid,
  input  logic [W-1:0]  resp_data,
  input  logic [W-1:0]  exp_data,
  input  logic [W-1:0]  golden_sig,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [W-1:0]  signature,
  output logic [CW-1:0] pat_count,
  output logic          fail_seen,
  output logic [CW-1:0] first_fail_idx
);

  ora_state_t    state_q, state_d;
  logic [CW-1:0] count_q;
  logic          pass_q;
  logic          start_run;
  logic          accept;
  logic          last_pat;

  // start is honoured only between runs; mid-run starts are dropped.
  assign start_run = start && ((state_q == StIdle) || (state_q == StDone));
  assign accept    = (state_q == StRun) && resp_valid;
  assign last_pat  = (count_q == CW'(NUM_PATTERNS - 1));

  bist_misr #(
    .W    (W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .load  (start_run),
    .en    (accept),
    .data  (resp_data),
    .sig   (signature)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (accept && last_pat) state_d = StCompare;
      StCompare:      state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    busy = (state_q == StRun) || (state_q == StCompare);
    done = (state_q == StDone);
  end

  // Pattern counter and pass flag; the counter wraps naturally at 2^CW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      if (start_run) begin
        count_q <= '0;
        pass_q  <= 1'b0;
      end else begin
        if (accept)                count_q <= count_q + 1'b1;
        if (state_q == StCompare)  pass_q  <= (signature == golden_sig);
      end
    end
  end

  assign pat_count = count_q;
  assign pass      = pass_q;

`ifdef BIST_ORA_FIRST_FAIL_EN
  logic          fail_q;
  logic [CW-1:0] fail_idx_q;

  // Capture the index of the first accepted response that differs from exp_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
    end else if (start_run) begin
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
    end else if (accept && !fail_q && (resp_data != exp_data)) begin
      fail_q     <= 1'b1;
      fail_idx_q <= count_q;
    end
  end

  assign fail_seen      = fail_q;
  assign first_fail_idx = fail_idx_q;
`else
  logic unused_exp;
  assign unused_exp     = ^exp_data;
  assign fail_seen      = 1'b0;
  assign first_fail_idx = '0;
`endif

endmodule

// File: tb/tb_bist_ora.sv
// Self-checking bench for bist_ora (NUM_PATTERNS=4) against a polynomial-arithmetic model.
module tb_bist_ora;

  localparam int unsigned NP = 4;
  localparam int unsigned W  = 9;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          resp_valid;
  logic [W-1:0]  resp_data;
  logic [W-1:0]  exp_data;
  logic [W-1:0]  golden_sig;
  logic          busy;
  logic          done;
  logic          pass;
  logic [W-1:0]  signature;
  logic [CW-1:0] pat_count;
  logic          fail_seen;
  logic [CW-1:0] first_fail_idx;

  bist_ora #(
    .W            (W),
    .NUM_PATTERNS (NP),
    .POLY         (9'h011),
    .SEED         (9'h000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .exp_data       (exp_data),
    .golden_sig     (golden_sig),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .signature      (signature),
    .pat_count      (pat_count),
    .fail_seen      (fail_seen),
    .first_fail_idx (first_fail_idx)
  );

  always #5 clk = ~clk;

`ifdef BIST_ORA_FIRST_FAIL_EN
  localparam bit FfEn = 1'b1;
`else
  localparam bit FfEn = 1'b0;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  resp_v[NP];
  logic [8:0]  exp_v[NP];
  logic [8:0]  sig_hist[$];
  logic [8:0]  sig_res;
  logic [8:0]  sig_ref;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Signature as a polynomial over GF(2): s(x)*x mod (x^9+x^4+1), plus the new response.
  function automatic int misr_ref(input int s, input int d);
    int t;
    t = s * 2;
    if (t >= 512) t = t ^ 'h211;
    return t ^ d;
  endfunction

  function automatic logic [8:0] model_sig();
    int s;
    s = 0;
    for (int i = 0; i < int'(NP); i++) s = misr_ref(s, int'(resp_v[i]));
    return 9'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run; gap_mode 0: back-to-back, 1: one idle cycle per response, 2: random idles.
  task automatic run(input logic [8:0] golden, input int gap_mode, output logic [8:0] sig_out);
    int s;
    int ff_idx;
    int gaps;
    s      = 0;
    ff_idx = -1;
    golden_sig = golden;
    start      = 1'b1;
    resp_valid = 1'($urandom_range(0, 1));
    resp_data  = 9'($urandom);
    exp_data   = 9'($urandom);
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_sig", 32'(signature), 32'd0);
    check("start_cnt", 32'(pat_count), 32'd0);
    sig_hist.delete();
    for (int i = 0; i < int'(NP); i++) begin
      gaps = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gaps; g++) begin
        resp_valid = 1'b0;
        resp_data  = 9'($urandom);
        start      = 1'($urandom_range(0, 1));
        tick();
        check("gap_cnt", 32'(pat_count), 32'(i));
        check("gap_sig", 32'(signature), 32'(s));
        check("gap_busy", 32'(busy), 32'd1);
      end
      start      = 1'b0;
      resp_valid = 1'b1;
      resp_data  = resp_v[i];
      exp_data   = exp_v[i];
      tick();
      s = misr_ref(s, int'(resp_v[i]));
      if (ff_idx < 0 && resp_v[i] != exp_v[i]) ff_idx = i;
      sig_hist.push_back(signature);
      check("acc_sig", 32'(signature), 32'(s));
      check("acc_cnt", 32'(pat_count), 32'((i + 1) % int'(NP)));
      check("acc_busy", 32'(busy), 32'd1);
      check("acc_done", 32'(done), 32'd0);
    end
    // Compare cycle: responses and start must be ignored.
    resp_valid = 1'($urandom_range(0, 1));
    resp_data  = 9'($urandom);
    start      = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_sig", 32'(signature), 32'(s));
    check("end_pass", 32'(pass), 32'(9'(s) == golden));
    check("end_fail_seen", 32'(fail_seen), 32'(FfEn && ff_idx >= 0));
    check("end_ff_idx", 32'(first_fail_idx), (FfEn && ff_idx >= 0) ? 32'(ff_idx) : 32'd0);
    // Done holds its results while responses keep arriving.
    resp_valid = 1'b1;
    resp_data  = 9'($urandom);
    tick();
    resp_valid = 1'b0;
    check("hold_done", 32'(done), 32'd1);
    check("hold_sig", 32'(signature), 32'(s));
    check("hold_pass", 32'(pass), 32'(9'(s) == golden));
    sig_out = 9'(s);
  endtask

  task automatic set_resps(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c,
                           input logic [8:0] d);
    resp_v[0] = a; resp_v[1] = b; resp_v[2] = c; resp_v[3] = d;
    for (int i = 0; i < int'(NP); i++) exp_v[i] = resp_v[i];
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    exp_data   = '0;
    golden_sig = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_sig", 32'(signature), 32'd0);
    check("rst_cnt", 32'(pat_count), 32'd0);
    check("rst_fail", 32'(fail_seen), 32'd0);
    check("rst_ffidx", 32'(first_fail_idx), 32'd0);
    reset = 1'b0;
    tick();

    // All-zero responses.
    set_resps(9'h000, 9'h000, 9'h000, 9'h000);
    run(9'h000, 0, sig_res);
    check("zero_sig", 32'(sig_res), 32'h000);
    check("zero_pass", 32'(pass), 32'd1);

    // Single one shifted up to x^3.
    set_resps(9'h001, 9'h000, 9'h000, 9'h000);
    run(9'h008, 0, sig_res);
    check("one_sig", 32'(sig_res), 32'h008);
    check("one_pass", 32'(pass), 32'd1);
    run(9'h009, 0, sig_res);
    check("one_badgold", 32'(pass), 32'd0);

    // Feedback wrap from bit 8.
    set_resps(9'h100, 9'h000, 9'h000, 9'h000);
    run(9'h000, 0, sig_res);
    check("wrap_sig", 32'(sig_hist[1]), 32'h011);

    // Alternating gaps give the same signature as back-to-back.
    set_resps(9'h001, 9'h000, 9'h000, 9'h000);
    run(9'h008, 1, sig_res);
    check("gap_same_sig", 32'(sig_res), 32'h008);

    // Reset in the middle of a run.
    set_resps(9'h1a5, 9'h03c, 9'h0f0, 9'h111);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_valid = 1'b1;
      resp_data  = resp_v[i];
      exp_data   = ~resp_v[i];
      tick();
    end
    resp_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sig", 32'(signature), 32'd0);
    check("midrst_cnt", 32'(pat_count), 32'd0);
    check("midrst_fail", 32'(fail_seen), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    sig_ref = model_sig();
    run(sig_ref, 0, sig_res);
    check("midrst_rerun_pass", 32'(pass), 32'd1);

    // Per-pattern mismatches at patterns 2 and 3.
    set_resps(9'h055, 9'h0aa, 9'h123, 9'h1ff);
    exp_v[2] = 9'h124;
    exp_v[3] = 9'h000;
    run(model_sig(), 0, sig_res);
    check("ff_seen", 32'(fail_seen), 32'(FfEn));
    check("ff_idx", 32'(first_fail_idx), FfEn ? 32'd2 : 32'd0);
    check("ff_pass", 32'(pass), 32'd1);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < int'(NP); i++) begin
        resp_v[i] = 9'($urandom);
        exp_v[i]  = ($urandom_range(0, 3) == 0) ? 9'($urandom) : resp_v[i];
      end
      sig_ref = model_sig();
      run(($urandom_range(0, 1) == 1) ? sig_ref : 9'($urandom), 2, sig_res);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
